// File: rtl/instruction_decode_stage_pkg.sv
// Shared format codes, opcode constants and the stored entry layout for the decode stage.
package instruction_decode_stage_pkg;

  typedef enum logic [2:0] {
    RType       = 3'd0,
    IType       = 3'd1,
    SType       = 3'd2,
    BType       = 3'd3,
    UType       = 3'd4,
    JType       = 3'd5,
    InvalidType = 3'd7
  } instr_type_e;

  localparam logic [6:0] OpcodeOp      = 7'b0110011;
  localparam logic [6:0] OpcodeOpImm   = 7'b0010011;
  localparam logic [6:0] OpcodeLoad    = 7'b0000011;
  localparam logic [6:0] OpcodeJalr    = 7'b1100111;
  localparam logic [6:0] OpcodeSystem  = 7'b1110011;
  localparam logic [6:0] OpcodeMiscMem = 7'b0001111;
  localparam logic [6:0] OpcodeStore   = 7'b0100011;
  localparam logic [6:0] OpcodeBranch  = 7'b1100011;
  localparam logic [6:0] OpcodeLui     = 7'b0110111;
  localparam logic [6:0] OpcodeAuipc   = 7'b0010111;
  localparam logic [6:0] OpcodeJal     = 7'b1101111;

  typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] pc;
    instr_type_e itype;
    logic        illegal;
  } entry_t;

endpackage

// File: rtl/instruction_decode_stage_opcode_classifier.sv
// Combinational opcode -> format classifier; unknown or non-32-bit encodings are flagged illegal.
module opcode_classifier
  import instruction_decode_stage_pkg::*;
(
  input  logic [31:0] instruction_i,
  output instr_type_e instr_type_o,
  output logic        illegal_o
);

  // Every supported opcode ends in 2'b11, so compressed and zero words fall to the default.
  always_comb begin
    instr_type_o = InvalidType;
    case (instruction_i[6:0])
      OpcodeOp:                             instr_type_o = RType;
      OpcodeOpImm, OpcodeLoad, OpcodeJalr,
      OpcodeSystem, OpcodeMiscMem:          instr_type_o = IType;
      OpcodeStore:                          instr_type_o = SType;
      OpcodeBranch:                         instr_type_o = BType;
      OpcodeLui, OpcodeAuipc:               instr_type_o = UType;
      OpcodeJal:                            instr_type_o = JType;
      default:                              instr_type_o = InvalidType;
    endcase
    illegal_o = (instr_type_o == InvalidType);
  end

endmodule

// File: rtl/instruction_decode_stage.sv
// Registered decode stage: classifies fetched words and holds them in a 2-entry skid buffer
// so that in_ready can be a flop while sustaining one word per cycle.
module instruction_decode_stage
  import instruction_decode_stage_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter logic [31:0] RESET_NOP = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instruction,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instruction,
  output logic [XLEN-1:0] out_pc,
  output logic [2:0]      out_instruction_type,
  output logic            out_illegal
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  localparam entry_t ResetEntry = '{
    instruction: RESET_NOP,
    pc:          '0,
    itype:       IType,
    illegal:     1'b0
  };

  state_e      state_q;
  entry_t      main_q, skid_q, in_entry;
  logic        in_ready_q;
  instr_type_e in_type;
  logic        in_illegal;
  logic        main_valid, accept, pop;

  opcode_classifier u_classifier (
    .instruction_i (in_instruction),
    .instr_type_o  (in_type),
    .illegal_o     (in_illegal)
  );

  always_comb begin
    in_entry = '{instruction: in_instruction, pc: in_pc, itype: in_type, illegal: in_illegal};
  end

  assign main_valid = (state_q != StEmpty);
  assign accept     = in_valid && in_ready_q;
  assign pop        = main_valid && out_ready;

  // Flush wins over any handshake; a concurrent pop is simply absorbed by the emptying.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StEmpty;
      in_ready_q <= 1'b1;
      main_q     <= ResetEntry;
      skid_q     <= ResetEntry;
    end else if (flush) begin
      state_q    <= StEmpty;
      in_ready_q <= 1'b1;
    end else begin
      case (state_q)
        StEmpty: begin
          if (accept) begin
            main_q  <= in_entry;
            state_q <= StOne;
          end
        end
        StOne: begin
          if (accept && pop) begin
            main_q <= in_entry;
          end else if (accept) begin
            skid_q     <= in_entry;
            state_q    <= StFull;
            in_ready_q <= 1'b0;
          end else if (pop) begin
            state_q <= StEmpty;
          end
        end
        StFull: begin
          if (pop) begin
            main_q     <= skid_q;
            state_q    <= StOne;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= StEmpty;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready             = in_ready_q;
  assign out_valid            = main_valid;
  assign out_instruction      = main_q.instruction;
  assign out_pc               = main_q.pc;
  assign out_instruction_type = main_q.itype;
  assign out_illegal          = main_q.illegal;

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Directed vector table, hand-written backpressure/flush/reset sequences and a scoreboarded
// random stream for instruction_decode_stage.
module tb_instruction_decode_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instruction = 32'h0;
  logic [31:0] in_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;
  logic [2:0]  out_instruction_type;
  logic        out_illegal;

  int passed = 0;
  int total  = 0;

  instruction_decode_stage dut (
    .clk                  (clk),
    .reset                (reset),
    .flush                (flush),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .in_instruction       (in_instruction),
    .in_pc                (in_pc),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .out_instruction      (out_instruction),
    .out_pc               (out_pc),
    .out_instruction_type (out_instruction_type),
    .out_illegal          (out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  etype;
    logic        eill;
  } vec_t;

  vec_t        vecs[14];
  logic [6:0]  opc_pool[14];
  logic [63:0] sb[$];
  logic [31:0] pc_ctr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] ref_class(input logic [31:0] w);
    case (w[6:0])
      7'h33:                             return {1'b0, 3'd0};
      7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: return {1'b0, 3'd1};
      7'h23:                             return {1'b0, 3'd2};
      7'h63:                             return {1'b0, 3'd3};
      7'h37, 7'h17:                      return {1'b0, 3'd4};
      7'h6F:                             return {1'b0, 3'd5};
      default:                           return {1'b1, 3'd7};
    endcase
  endfunction

  // One scoreboarded cycle: inputs applied, handshakes resolved from the pre-edge view.
  task automatic run_cycle(input logic iv, input logic orr);
    logic        acc, pp;
    logic [31:0] w;
    logic [63:0] head;
    logic [3:0]  cls;
    w = $urandom;
    w[6:0] = opc_pool[$urandom_range(0, 13)];
    in_valid = iv;
    in_instruction = w;
    in_pc = pc_ctr;
    out_ready = orr;
    acc = iv && in_ready;
    pp  = out_valid && orr;
    if (pp) begin
      if (sb.size() == 0) begin
        check("stress_unexpected_pop", 32'd1, 32'd0);
      end else begin
        head = sb[0];
        cls  = ref_class(head[63:32]);
        check("stress_pc", out_pc, head[31:0]);
        check("stress_instr", out_instruction, head[63:32]);
        check("stress_type", {29'd0, out_instruction_type}, {29'd0, cls[2:0]});
        check("stress_illegal", {31'd0, out_illegal}, {31'd0, cls[3]});
      end
    end
    tick();
    if (pp && sb.size() != 0) void'(sb.pop_front());
    if (acc) begin
      sb.push_back({w, pc_ctr});
      pc_ctr = pc_ctr + 32'd4;
    end
    check("stress_out_valid", {31'd0, out_valid}, {31'd0, (sb.size() != 0)});
  endtask

  initial begin
    vecs[0]  = '{32'h00500093, 3'd1, 1'b0};
    vecs[1]  = '{32'h00112223, 3'd2, 1'b0};
    vecs[2]  = '{32'h008000EF, 3'd5, 1'b0};
    vecs[3]  = '{32'h00208033, 3'd0, 1'b0};
    vecs[4]  = '{32'h00208063, 3'd3, 1'b0};
    vecs[5]  = '{32'h000002B7, 3'd4, 1'b0};
    vecs[6]  = '{32'h00000297, 3'd4, 1'b0};
    vecs[7]  = '{32'h00002083, 3'd1, 1'b0};
    vecs[8]  = '{32'h0000000F, 3'd1, 1'b0};
    vecs[9]  = '{32'h00000073, 3'd1, 1'b0};
    vecs[10] = '{32'h00008067, 3'd1, 1'b0};
    vecs[11] = '{32'h00000000, 3'd7, 1'b1};
    vecs[12] = '{32'h0000007F, 3'd7, 1'b1};
    vecs[13] = '{32'h00004501, 3'd7, 1'b1};
    opc_pool[0]  = 7'h33; opc_pool[1]  = 7'h13; opc_pool[2]  = 7'h03; opc_pool[3]  = 7'h67;
    opc_pool[4]  = 7'h73; opc_pool[5]  = 7'h0F; opc_pool[6]  = 7'h23; opc_pool[7]  = 7'h63;
    opc_pool[8]  = 7'h37; opc_pool[9]  = 7'h17; opc_pool[10] = 7'h6F; opc_pool[11] = 7'h7F;
    opc_pool[12] = 7'h00; opc_pool[13] = 7'h31;

    // Reset state
    tick();
    tick();
    reset = 1'b0;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_instr", out_instruction, 32'h00000013);
    check("rst_pc", out_pc, 32'h0);
    check("rst_type", {29'd0, out_instruction_type}, 32'd1);
    check("rst_illegal", {31'd0, out_illegal}, 32'd0);

    // Classification table, one word per cycle
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      in_valid = 1'b1;
      in_instruction = vecs[i].instr;
      in_pc = 32'h1000 + 32'(i * 4);
      tick();
      in_valid = 1'b0;
      check("vec_out_valid", {31'd0, out_valid}, 32'd1);
      check("vec_instr", out_instruction, vecs[i].instr);
      check("vec_pc", out_pc, 32'h1000 + 32'(i * 4));
      check("vec_type", {29'd0, out_instruction_type}, {29'd0, vecs[i].etype});
      check("vec_illegal", {31'd0, out_illegal}, {31'd0, vecs[i].eill});
    end
    tick();
    check("vec_drain_empty", {31'd0, out_valid}, 32'd0);

    // Backpressure: two words absorbed, then in_ready drops
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instruction = 32'h00500093;
    in_pc = 32'h0;
    tick();
    check("bp_c1_pc", out_pc, 32'h0);
    check("bp_c1_in_ready", {31'd0, in_ready}, 32'd1);
    in_pc = 32'h4;
    tick();
    check("bp_c2_in_ready", {31'd0, in_ready}, 32'd0);
    in_pc = 32'h8;
    tick();
    check("bp_c3_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp_c3_pc", out_pc, 32'h0);
    out_ready = 1'b1;
    tick();
    check("bp_rel_pc4", out_pc, 32'h4);
    check("bp_rel_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp_rel_pc8", out_pc, 32'h8);
    check("bp_rel_valid", {31'd0, out_valid}, 32'd1);
    tick();
    check("bp_empty", {31'd0, out_valid}, 32'd0);

    // Flush from FULL with a word offered
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_pc = 32'h100;
    tick();
    in_pc = 32'h104;
    tick();
    check("fl_full", {31'd0, in_ready}, 32'd0);
    flush = 1'b1;
    in_pc = 32'h108;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("fl_out_valid", {31'd0, out_valid}, 32'd0);
    check("fl_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("fl_dropped", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b1;
    in_pc = 32'h10C;
    tick();
    check("fl_after_pc", out_pc, 32'h10C);
    // Flush while in_ready=1: offered word must still be dropped
    flush = 1'b1;
    in_pc = 32'h110;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_one_out_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("fl_one_dropped", {31'd0, out_valid}, 32'd0);

    // Reset while FULL
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instruction = 32'h00112223;
    in_pc = 32'h200;
    tick();
    in_pc = 32'h204;
    tick();
    check("rm_full", {31'd0, in_ready}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    check("rm_out_valid", {31'd0, out_valid}, 32'd0);
    check("rm_instr", out_instruction, 32'h00000013);
    check("rm_in_ready", {31'd0, in_ready}, 32'd1);
    check("rm_pc", out_pc, 32'h0);

    // Random stress against the scoreboard
    pc_ctr = 32'h4000;
    sb.delete();
    for (int c = 0; c < 10000; c++) begin
      run_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
    end
    for (int c = 0; c < 8; c++) run_cycle(1'b0, 1'b1);
    check("stress_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
